// File: rtl/sh7604_rfsh.sv
// sh7604_rfsh: SH7604 refresh timer and CBR refresh-request scheduler.
//
// The block holds RTCSR/RTCNT/RTCOR. It prescales the CE_R tick stream and counts
// compare matches. It raises the compare-match interrupt and queues CBR refresh
// requests, which it hands to the bus state controller with a REQ/ACK handshake.
//
// Configuration macro: SH7604_RFSH_QUEUE_EN
//   defined   - the pending counter is PEND_W bits wide.
//   undefined - the pending counter is 1 bit wide and PEND_W has no effect.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ce_r_i              rising-phase clock enable; all state advances only when high
//   ibus_a_i/di_i/we_i  internal bus address, write data and write qualifier
//   ibus_req_i          internal bus request
//   reg_do_o            registered read data, one cycle after the sampling CE_R
//   reg_sel_o           combinational decode of the FFFFFFF0..FFFFFFFB window
//   mcr_rfsh_i          refresh enable from MCR
//   mcr_rmode_i         self-refresh mode from MCR (suppresses CBR requests)
//   rfsh_req_o          refresh request (pending count non-zero)
//   rfsh_ack_i          one-CE_R pulse: the bus state controller started a refresh
//   rfsh_ovf_o          sticky: a match was lost because the queue was full
//   irq_o               CMF & CMIE
module sh7604_rfsh #(
    parameter int unsigned PEND_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_r_i,
    input  logic [31:0] ibus_a_i,
    input  logic [31:0] ibus_di_i,
    input  logic        ibus_we_i,
    input  logic        ibus_req_i,
    output logic [31:0] reg_do_o,
    output logic        reg_sel_o,
    input  logic        mcr_rfsh_i,
    input  logic        mcr_rmode_i,
    output logic        rfsh_req_o,
    input  logic        rfsh_ack_i,
    output logic        rfsh_ovf_o,
    output logic        irq_o
);

`ifdef SH7604_RFSH_QUEUE_EN
    localparam int unsigned PendW = PEND_W;
`else
    // Single-entry queue; PEND_W is referenced only so the parameter stays in use.
    localparam int unsigned PendW = (PEND_W > 0) ? 1 : 1;
`endif

    localparam logic [15:0] WrKey = 16'hA55A;

    // State
    logic             cmf_q, cmf_d;
    logic             cmie_q, cmie_d;
    logic [2:0]       cks_q, cks_d;
    logic [7:0]       rtcnt_q, rtcnt_d;
    logic [7:0]       rtcor_q, rtcor_d;
    logic [11:0]      presc_q, presc_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             cmf_rd_q, cmf_rd_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      reg_do_q, reg_do_d;

    // Decode
    logic [1:0]  offset;
    logic        wr_en, rd_en;
    logic        wr_csr, wr_cnt, wr_cor, rd_csr;
    logic [11:0] div_max;
    logic        tick, match, enq, ack_v, pend_full;
    logic [31:0] rtcsr_val;
    logic        unused_di;

    assign unused_di = ^ibus_di_i[15:9];

    assign reg_sel_o = (ibus_a_i >= 32'hFFFF_FFF0) && (ibus_a_i <= 32'hFFFF_FFFB);
    assign offset    = ibus_a_i[3:2];
    assign wr_en     = ibus_req_i & ibus_we_i & reg_sel_o & (ibus_di_i[31:16] == WrKey);
    assign rd_en     = ibus_req_i & ~ibus_we_i & reg_sel_o;
    assign wr_csr    = wr_en & (offset == 2'd0);
    assign wr_cnt    = wr_en & (offset == 2'd1);
    assign wr_cor    = wr_en & (offset == 2'd2);
    assign rd_csr    = rd_en & (offset == 2'd0);

    // Terminal prescaler count for each clock select; CKS=0 stops the timer.
    always_comb begin
        div_max = 12'd0;
        unique case (cks_q)
            3'd0: div_max = 12'd0;
            3'd1: div_max = 12'd3;
            3'd2: div_max = 12'd15;
            3'd3: div_max = 12'd63;
            3'd4: div_max = 12'd255;
            3'd5: div_max = 12'd1023;
            3'd6: div_max = 12'd2047;
            3'd7: div_max = 12'd4095;
        endcase
    end

    assign tick      = (cks_q != 3'd0) && (presc_q == div_max);
    assign match     = (rtcnt_q == rtcor_q);
    assign enq       = tick & match & mcr_rfsh_i & ~mcr_rmode_i;
    assign ack_v     = rfsh_ack_i & (pend_q != '0);
    assign pend_full = &pend_q;

    assign rtcsr_val = {23'd0, ovf_q, cmf_q, cmie_q, cks_q, 3'd0};

    always_comb begin
        // Prescaler
        presc_d = presc_q;
        if (wr_csr) begin
            presc_d = 12'd0;
        end else if (cks_q != 3'd0) begin
            presc_d = tick ? 12'd0 : presc_q + 12'd1;
        end

        // Counter: a register write overrides the tick's increment or clear
        rtcnt_d = rtcnt_q;
        if (wr_cnt) begin
            rtcnt_d = ibus_di_i[7:0];
        end else if (tick) begin
            rtcnt_d = match ? 8'd0 : rtcnt_q + 8'd1;
        end

        rtcor_d = wr_cor ? ibus_di_i[7:0] : rtcor_q;

        // Control/status
        cmie_d = wr_csr ? ibus_di_i[6]   : cmie_q;
        cks_d  = wr_csr ? ibus_di_i[5:3] : cks_q;

        // CMF clears only by writing 0 after having read it as 1; a match wins.
        cmf_d = cmf_q;
        if (wr_csr && !ibus_di_i[7] && cmf_rd_q) begin
            cmf_d = 1'b0;
        end
        if (tick && match) begin
            cmf_d = 1'b1;
        end

        cmf_rd_d = cmf_rd_q;
        if (wr_csr) begin
            cmf_rd_d = 1'b0;
        end else if (rd_csr && cmf_q) begin
            cmf_rd_d = 1'b1;
        end

        // Pending refresh queue
        pend_d = pend_q;
        if (!mcr_rfsh_i || mcr_rmode_i) begin
            pend_d = '0;
        end else if (enq && ack_v) begin
            pend_d = pend_q;
        end else if (enq) begin
            if (!pend_full) begin
                pend_d = pend_q + 1'b1;
            end
        end else if (ack_v) begin
            pend_d = pend_q - 1'b1;
        end

        // Overflow: a new loss takes priority over a same-cycle clear
        ovf_d = ovf_q;
        if (wr_csr && ibus_di_i[8]) begin
            ovf_d = 1'b0;
        end
        if (enq && pend_full && !ack_v) begin
            ovf_d = 1'b1;
        end

        // Read data
        reg_do_d = reg_do_q;
        if (rd_en) begin
            unique case (offset)
                2'd0: reg_do_d = rtcsr_val;
                2'd1: reg_do_d = {24'd0, rtcnt_q};
                2'd2: reg_do_d = {24'd0, rtcor_q};
                2'd3: reg_do_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmf_q    <= 1'b0;
            cmie_q   <= 1'b0;
            cks_q    <= 3'd0;
            rtcnt_q  <= 8'd0;
            rtcor_q  <= 8'd0;
            presc_q  <= 12'd0;
            pend_q   <= '0;
            cmf_rd_q <= 1'b0;
            ovf_q    <= 1'b0;
            reg_do_q <= 32'd0;
        end else if (ce_r_i) begin
            cmf_q    <= cmf_d;
            cmie_q   <= cmie_d;
            cks_q    <= cks_d;
            rtcnt_q  <= rtcnt_d;
            rtcor_q  <= rtcor_d;
            presc_q  <= presc_d;
            pend_q   <= pend_d;
            cmf_rd_q <= cmf_rd_d;
            ovf_q    <= ovf_d;
            reg_do_q <= reg_do_d;
        end
    end

    assign reg_do_o   = reg_do_q;
    assign rfsh_req_o = (pend_q != '0);
    assign rfsh_ovf_o = ovf_q;
    assign irq_o      = cmf_q & cmie_q;

endmodule

// File: tb/tb_sh7604_rfsh.sv
module tb_sh7604_rfsh;

    logic        clk;
    logic        rst;
    logic        ce_r;
    logic [31:0] ibus_a;
    logic [31:0] ibus_di;
    logic        ibus_we;
    logic        ibus_req;
    logic [31:0] reg_do;
    logic        reg_sel;
    logic        mcr_rfsh;
    logic        mcr_rmode;
    logic        rfsh_req;
    logic        rfsh_ack;
    logic        rfsh_ovf;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ACsr = 32'hFFFF_FFF0;
    localparam logic [31:0] ACnt = 32'hFFFF_FFF4;
    localparam logic [31:0] ACor = 32'hFFFF_FFF8;

    sh7604_rfsh #(.PEND_W(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ce_r_i     (ce_r),
        .ibus_a_i   (ibus_a),
        .ibus_di_i  (ibus_di),
        .ibus_we_i  (ibus_we),
        .ibus_req_i (ibus_req),
        .reg_do_o   (reg_do),
        .reg_sel_o  (reg_sel),
        .mcr_rfsh_i (mcr_rfsh),
        .mcr_rmode_i(mcr_rmode),
        .rfsh_req_o (rfsh_req),
        .rfsh_ack_i (rfsh_ack),
        .rfsh_ovf_o (rfsh_ovf),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ibus_a   = a;
        ibus_di  = d;
        ibus_we  = 1'b1;
        ibus_req = 1'b1;
        step();
        ibus_req = 1'b0;
        ibus_we  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        ibus_a   = a;
        ibus_we  = 1'b0;
        ibus_req = 1'b1;
        step();
        ibus_req = 1'b0;
    endtask

    task automatic ack_pulse();
        rfsh_ack = 1'b1;
        step();
        rfsh_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce_r = 1'b1; ibus_a = 32'd0; ibus_di = 32'd0; ibus_we = 1'b0;
        ibus_req = 1'b0; mcr_rfsh = 1'b0; mcr_rmode = 1'b0; rfsh_ack = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_req", {31'd0, rfsh_req}, 32'd0);
        check("rst_ovf", {31'd0, rfsh_ovf}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_do", reg_do, 32'd0);

        // Window decode edges
        ibus_a = 32'hFFFF_FFFB; #1;
        check("sel_fb", {31'd0, reg_sel}, 32'd1);
        ibus_a = 32'hFFFF_FFFC; #1;
        check("sel_fc", {31'd0, reg_sel}, 32'd0);
        ibus_a = 32'hFFFF_FFEF; #1;
        check("sel_ef", {31'd0, reg_sel}, 32'd0);

        // First match: RTCOR=3, CKS=/4, CMIE=1 -> REQ 16 CE_R after the RTCSR write
        mcr_rfsh = 1'b1;
        bus_write(ACor, 32'hA55A_0003);
        bus_write(ACsr, 32'hA55A_0048);
        repeat (15) step();
        check("req_before_match", {31'd0, rfsh_req}, 32'd0);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        step();
        check("req_at_match", {31'd0, rfsh_req}, 32'd1);
        check("irq_at_match", {31'd0, irq}, 32'd1);
        bus_read(ACnt);
        check("rtcnt_after_match", reg_do, 32'd0);
        ack_pulse();
        check("req_after_ack", {31'd0, rfsh_req}, 32'd0);

        // Stop timer; writing CMF=0 without a prior read leaves CMF set
        bus_write(ACsr, 32'hA55A_0040);
        check("irq_no_read_clear", {31'd0, irq}, 32'd1);

        // Write key
        bus_write(ACnt, 32'h1234_0005);
        bus_read(ACnt);
        check("rtcnt_bad_key", reg_do, 32'd0);
        bus_write(ACnt, 32'hA55A_0005);
        bus_read(ACnt);
        check("rtcnt_good_key", reg_do, 32'd5);

        // Read-then-write-0 clears CMF
        bus_read(ACsr);
        check("rtcsr_cmf_set", reg_do, 32'h0000_00C0);
        bus_write(ACsr, 32'hA55A_0040);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(ACsr);
        check("rtcsr_cmf_clr", reg_do, 32'h0000_0040);
        bus_write(ACsr, 32'hA55A_00C0);
        bus_read(ACsr);
        check("rtcsr_cmf_w1", reg_do, 32'h0000_0040);

        // Overflow: RTCOR=0 -> match every tick (every 4 CE_R)
        bus_write(ACor, 32'hA55A_0000);
        bus_write(ACnt, 32'hA55A_0000);
        bus_write(ACsr, 32'hA55A_0008);
        repeat (4) step();
        check("ovf_req_first", {31'd0, rfsh_req}, 32'd1);
        check("ovf_first", {31'd0, rfsh_ovf}, 32'd0);
`ifdef SH7604_RFSH_QUEUE_EN
        repeat (8) step();
        check("ovf_third", {31'd0, rfsh_ovf}, 32'd0);
        repeat (4) step();
        check("ovf_fourth", {31'd0, rfsh_ovf}, 32'd1);
        bus_write(ACsr, 32'hA55A_0000);
        ack_pulse();
        check("q_ack1", {31'd0, rfsh_req}, 32'd1);
        ack_pulse();
        check("q_ack2", {31'd0, rfsh_req}, 32'd1);
        ack_pulse();
        check("q_ack3", {31'd0, rfsh_req}, 32'd0);
`else
        repeat (4) step();
        check("ovf_second", {31'd0, rfsh_ovf}, 32'd1);
        check("ovf_req_second", {31'd0, rfsh_req}, 32'd1);
        bus_write(ACsr, 32'hA55A_0000);
        ack_pulse();
        check("ovf_ack", {31'd0, rfsh_req}, 32'd0);
`endif
        bus_read(ACsr);
        check("rtcsr_ovf", reg_do, 32'h0000_0180);
        bus_write(ACsr, 32'hA55A_0100);
        bus_read(ACsr);
        check("rtcsr_ovf_clr", reg_do, 32'h0000_0000);
        check("ovf_pin_clr", {31'd0, rfsh_ovf}, 32'd0);

        // ACK coincident with a match at PEND=1
        bus_write(ACsr, 32'hA55A_0008);
        repeat (4) step();
        check("coin_req_pre", {31'd0, rfsh_req}, 32'd1);
        repeat (3) step();
        ack_pulse();
        check("coin_req", {31'd0, rfsh_req}, 32'd1);
        check("coin_ovf", {31'd0, rfsh_ovf}, 32'd0);
        bus_write(ACsr, 32'hA55A_0000);

        // Refresh disable drops the queue
        mcr_rfsh = 1'b0;
        step();
        check("rfsh_off_req", {31'd0, rfsh_req}, 32'd0);

        // Reset clears registers
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_read(ACsr);
        check("post_rst_csr", reg_do, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
